// File: rtl/vpu_mem_arbiter_pkg.sv
// Shared widths and helpers for the VPU memory arbiter slice.
package vpu_mem_arbiter_pkg;

    localparam int XLEN         = 32;
    localparam int RAM_DATA_WID = 32;
    localparam int RAM_ADDR_WID = 17;

    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } acc_kind_e;

    // Channel id width; never narrower than one bit.
    function automatic int ch_id_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/vpu_mem_arbiter_rr.sv
// Round-robin grant: first requesting channel at or after ptr, scanning upward modulo NUM_CH.
module vpu_mem_arbiter_rr #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [ID_W-1:0]   grant_idx,
    output logic              grant_any
);

    int  c;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        c         = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = (int'(ptr) + i) % NUM_CH;
            if (!found && req[c]) begin
                found     = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = ID_W'(c);
            end
        end
    end

    assign grant_any = found;

endmodule

// File: rtl/vpu_mem_arbiter.sv
// Shares one RAM port among NUM_CH requesters; read data returns to the issuing channel
// 1+RD_LAT cycles after its handshake.
module vpu_mem_arbiter
    import vpu_mem_arbiter_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = XLEN,
    parameter int DATA_W     = RAM_DATA_WID,
    parameter int RAM_ADDR_W = RAM_ADDR_WID,
    parameter int RD_LAT     = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [RAM_ADDR_W-1:0]    ram_addr,
    output logic                     ram_we,
    output logic [DATA_W-1:0]        ram_din,
    input  logic [DATA_W-1:0]        ram_dout
);

    localparam int ID_W = ch_id_w(NUM_CH);

    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       next_ptr;
    logic [NUM_CH-1:0]     grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  grant_any;
    logic                  fire;

    acc_kind_e             sel_kind;
    logic [RAM_ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_wdata;

    logic                  iss_rd;
    logic [ID_W-1:0]       iss_id;
    logic [RD_LAT-1:0]     pipe_vld;
    logic [ID_W-1:0]       pipe_id [RD_LAT];
    logic                  rsp_hit;

    // Address bits above the RAM width alias by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr;

    vpu_mem_arbiter_rr #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = rst_in ? '0 : grant;
    assign fire      = grant_any && !rst_in;
    assign next_ptr  = (grant_idx == ID_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        sel_kind  = ACC_READ;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_kind  = acc_kind_e'(req_we[i]);
                sel_addr  = req_addr[i*ADDR_W +: RAM_ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_ptr   <= '0;
            ram_addr <= '0;
            ram_we   <= 1'b0;
            ram_din  <= '0;
            iss_rd   <= 1'b0;
            iss_id   <= '0;
        end else begin
            ram_we <= fire && (sel_kind == ACC_WRITE);
            iss_rd <= fire && (sel_kind == ACC_READ);
            if (fire) begin
                rr_ptr   <= next_ptr;
                ram_addr <= sel_addr;
                ram_din  <= sel_wdata;
                iss_id   <= grant_idx;
            end
        end
    end

    // The issue register is the first tag stage; RD_LAT more stages line up with ram_dout.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= iss_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        pipe_id[0] <= iss_id;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_id[i] <= pipe_id[i-1];
        end
    end

    assign rsp_hit = pipe_vld[RD_LAT-1] && !rst_in;

    always_comb begin
        rsp_valid = '0;
        if (rsp_hit) begin
            rsp_valid[pipe_id[RD_LAT-1]] = 1'b1;
        end
    end

    assign rsp_rdata = rsp_hit ? ram_dout : '0;

endmodule

// File: tb/tb_vpu_mem_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a queue-based model,
// driving one RD_LAT=1 and one RD_LAT=3 instance from the same requesters.
module tb_vpu_mem_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int RAW = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_we    = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;

    logic [N-1:0]    ready1, rspv1, ready3, rspv3;
    logic [DW-1:0]   rdata1, rdata3, din1, din3;
    logic [DW-1:0]   dout1 = '0, dout3 = '0;
    logic [RAW-1:0]  raddr1, raddr3;
    logic            we1, we3;

    vpu_mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RAM_ADDR_W(RAW), .RD_LAT(1)) dut (
        .clk_in(clk), .rst_in(rst), .req_valid(req_valid), .req_ready(ready1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rspv1), .rsp_rdata(rdata1), .ram_addr(raddr1), .ram_we(we1),
        .ram_din(din1), .ram_dout(dout1));

    vpu_mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RAM_ADDR_W(RAW), .RD_LAT(3)) dut3 (
        .clk_in(clk), .rst_in(rst), .req_valid(req_valid), .req_ready(ready3),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rspv3), .rsp_rdata(rdata3), .ram_addr(raddr3), .ram_we(we3),
        .ram_din(din3), .ram_dout(dout3));

    // RAM models; a backdoor load port avoids writing the arrays from two processes.
    bit [31:0] ram1 [0:4095];
    bit [31:0] ram3 [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] r3a = '0, r3b = '0;

    always @(posedge clk) begin
        dout1 <= ram1[raddr1[11:0]];
        if (pl_en)    ram1[pl_addr]      <= pl_data;
        else if (we1) ram1[raddr1[11:0]] <= din1;
    end

    always @(posedge clk) begin
        r3a   <= ram3[raddr3[11:0]];
        r3b   <= r3a;
        dout3 <= r3b;
        if (pl_en)    ram3[pl_addr]      <= pl_data;
        else if (we3) ram3[raddr3[11:0]] <= din3;
    end

    int compared   = 0;
    int mismatched = 0;
    bit [31:0] refm [bit [16:0]];

    typedef struct {
        int        due;
        int        ch;
        bit [31:0] data;
    } exp_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input bit we, input logic [31:0] addr, input logic [31:0] wd);
        req_valid[ch]           = 1'b1;
        req_we[ch]              = we;
        req_addr[ch*AW +: AW]   = addr;
        req_wdata[ch*DW +: DW]  = wd;
    endtask

    task automatic preload(input logic [16:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a[11:0]; pl_data = d;
        refm[a] = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        req_we = '0;
        tick();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            compared++;
            if (ready1 !== 4'b0000) begin mismatched++; $display("FAIL reset_ready got %b want 0000", ready1); end
            compared++;
            if (rspv1 !== 4'b0000) begin mismatched++; $display("FAIL reset_rsp got %b want 0000", rspv1); end
            compared++;
            if (we1 !== 1'b0 || raddr1 !== '0 || din1 !== '0) begin
                mismatched++; $display("FAIL reset_ram got we=%b addr=%h din=%h want 0", we1, raddr1, din1);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h200 + 32'(i*4), 32'h0);
        for (int k = 0; k < 8; k++) begin
            logic [3:0] want;
            want = 4'(1 << (k % N));
            @(negedge clk);
            compared++;
            if (ready1 !== want) begin mismatched++; $display("FAIL rr_grant[%0d] got %b want %b", k, ready1, want); end
            compared++;
            if (ready3 !== want) begin mismatched++; $display("FAIL rr_grant3[%0d] got %b want %b", k, ready3, want); end
            tick();
        end
        req_valid = '0;
        repeat (8) tick();
    endtask

    task automatic test_single_read();
        preload(17'h40, 32'hDEADBEEF);
        req_valid = '0;
        set_req(2, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        compared++;
        if (ready1 !== 4'b0100) begin mismatched++; $display("FAIL rd_grant got %b want 0100", ready1); end
        tick();
        req_valid = '0;
        @(negedge clk);
        compared++;
        if (raddr1 !== 17'h40 || we1 !== 1'b0 || rspv1 !== 4'b0000) begin
            mismatched++; $display("FAIL rd_issue got addr=%h we=%b rsp=%b want 40/0/0000", raddr1, we1, rspv1);
        end
        tick();
        @(negedge clk);
        compared++;
        if (rspv1 !== 4'b0100 || rdata1 !== 32'hDEADBEEF) begin
            mismatched++; $display("FAIL rd_rsp got %b/%h want 0100/deadbeef", rspv1, rdata1);
        end
        tick();
        @(negedge clk);
        compared++;
        if (rspv1 !== 4'b0000 || rdata1 !== 32'h0) begin
            mismatched++; $display("FAIL rd_rsp_once got %b/%h want 0000/0", rspv1, rdata1);
        end
        repeat (6) tick();
    endtask

    task automatic test_write_then_read();
        req_valid = '0;
        set_req(1, 1'b1, 32'h10, 32'h1234);
        @(negedge clk);
        compared++;
        if (ready1 !== 4'b0010) begin mismatched++; $display("FAIL wr_grant got %b want 0010", ready1); end
        tick();
        req_valid = '0;
        set_req(3, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        compared++;
        if (ready1 !== 4'b1000 || we1 !== 1'b1 || raddr1 !== 17'h10 || din1 !== 32'h1234) begin
            mismatched++;
            $display("FAIL wr_issue got rdy=%b we=%b addr=%h din=%h want 1000/1/10/1234", ready1, we1, raddr1, din1);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        compared++;
        if (rspv1 !== 4'b0000 || we1 !== 1'b0) begin
            mismatched++; $display("FAIL wr_no_rsp got rsp=%b we=%b want 0000/0", rspv1, we1);
        end
        tick();
        @(negedge clk);
        compared++;
        if (rspv1 !== 4'b1000 || rdata1 !== 32'h1234) begin
            mismatched++; $display("FAIL raw_rsp got %b/%h want 1000/1234", rspv1, rdata1);
        end
        repeat (6) tick();
    endtask

    task automatic test_latency();
        preload(17'h100, 32'hA5A50001);
        preload(17'h104, 32'h5A5A0002);
        for (int k = 0; k < 8; k++) begin
            logic [3:0]  wv;
            logic [31:0] wd;
            req_valid = '0;
            if (k == 0) set_req(0, 1'b0, 32'h100, 32'h0);
            if (k == 1) set_req(1, 1'b0, 32'h104, 32'h0);
            wv = (k == 4) ? 4'b0001 : (k == 5) ? 4'b0010 : 4'b0000;
            wd = (k == 4) ? 32'hA5A50001 : (k == 5) ? 32'h5A5A0002 : 32'h0;
            @(negedge clk);
            compared++;
            if (rspv3 !== wv || rdata3 !== wd) begin
                mismatched++; $display("FAIL lat3_rsp[T+%0d] got %b/%h want %b/%h", k, rspv3, rdata3, wv, wd);
            end
            tick();
        end
        req_valid = '0;
        repeat (4) tick();
    endtask

    task automatic test_mid_reset();
        req_valid = '0;
        set_req(2, 1'b0, 32'h40, 32'h0);
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            compared++;
            if (rspv1 !== 4'b0000 || rspv3 !== 4'b0000) begin
                mismatched++; $display("FAIL midrst_rsp[%0d] got %b/%b want 0000/0000", k, rspv1, rspv3);
            end
            tick();
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h300 + 32'(i*4), 32'h0);
        @(negedge clk);
        compared++;
        if (ready1 !== 4'b0001 || ready3 !== 4'b0001) begin
            mismatched++; $display("FAIL midrst_first got %b/%b want 0001", ready1, ready3);
        end
        tick();
        req_valid = '0;
        repeat (8) tick();
    endtask

    task automatic test_random();
        bit          pend [N];
        bit          mwe  [N];
        logic [31:0] maddr[N];
        logic [31:0] mwd  [N];
        exp_t        q1[$];
        exp_t        q3[$];
        int          ptr;
        int          g;
        bit          prev_g;
        bit          prev_we;
        logic [16:0] prev_a;
        logic [31:0] prev_d;

        for (int j = 0; j < 8; j++) preload(17'h800 + 17'(j*4), $urandom());
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ptr = 0;
        prev_g = 1'b0; prev_we = 1'b0; prev_a = '0; prev_d = '0;

        for (int c = 0; c < 420; c++) begin
            logic [3:0]  want;
            logic [3:0]  wv1, wv3;
            logic [31:0] wd1, wd3;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && c < 400 && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1'b1;
                    mwe[i]   = ($urandom_range(0, 2) == 0);
                    maddr[i] = ($urandom() & 32'hFFFE_0000) | (32'h800 + 32'($urandom_range(0, 7)) * 4);
                    mwd[i]   = $urandom();
                end
                req_valid[i] = pend[i];
                if (pend[i]) set_req(i, mwe[i], maddr[i], mwd[i]);
            end
            g = -1;
            for (int k = 0; k < N; k++) begin
                int ch;
                ch = (ptr + k) % N;
                if (g < 0 && pend[ch]) g = ch;
            end
            want = (g >= 0) ? 4'(1 << g) : 4'b0000;

            wv1 = '0; wd1 = '0; wv3 = '0; wd3 = '0;
            if (q1.size() > 0 && q1[0].due == c) begin
                wv1 = 4'(1 << q1[0].ch); wd1 = q1[0].data; void'(q1.pop_front());
            end
            if (q3.size() > 0 && q3[0].due == c) begin
                wv3 = 4'(1 << q3[0].ch); wd3 = q3[0].data; void'(q3.pop_front());
            end

            @(negedge clk);
            compared++;
            if (ready1 !== want || ready3 !== want) begin
                mismatched++; $display("FAIL rnd_grant c=%0d got %b/%b want %b", c, ready1, ready3, want);
            end
            compared++;
            if (rspv1 !== wv1 || rdata1 !== wd1) begin
                mismatched++; $display("FAIL rnd_rsp1 c=%0d got %b/%h want %b/%h", c, rspv1, rdata1, wv1, wd1);
            end
            compared++;
            if (rspv3 !== wv3 || rdata3 !== wd3) begin
                mismatched++; $display("FAIL rnd_rsp3 c=%0d got %b/%h want %b/%h", c, rspv3, rdata3, wv3, wd3);
            end
            if (prev_g) begin
                compared++;
                if (raddr1 !== prev_a || we1 !== prev_we || (prev_we && din1 !== prev_d)) begin
                    mismatched++;
                    $display("FAIL rnd_issue c=%0d got %h/%b/%h want %h/%b/%h", c, raddr1, we1, din1, prev_a, prev_we, prev_d);
                end
            end else begin
                compared++;
                if (we1 !== 1'b0) begin mismatched++; $display("FAIL rnd_idle_we c=%0d got %b want 0", c, we1); end
            end

            prev_g = (g >= 0);
            if (g >= 0) begin
                logic [16:0] a;
                a       = maddr[g][16:0];
                prev_a  = a;
                prev_we = mwe[g];
                prev_d  = mwd[g];
                ptr     = (g + 1) % N;
                if (mwe[g]) begin
                    refm[a] = mwd[g];
                end else begin
                    q1.push_back('{due: c + 2, ch: g, data: refm[a]});
                    q3.push_back('{due: c + 4, ch: g, data: refm[a]});
                end
                pend[g] = 1'b0;
            end
            tick();
        end
        compared++;
        if (q1.size() != 0 || q3.size() != 0) begin
            mismatched++; $display("FAIL rnd_drain got %0d/%0d outstanding want 0/0", q1.size(), q3.size());
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_write_then_read();
        test_latency();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
